// File: rtl/pool_pkg.sv
// Shared constants and lane-field helpers for the execution-unit pool arbiter.
package pool_pkg;

  localparam int N_SRC_DEF   = 5;
  localparam int N_REG_DEF   = 8;
  localparam int STAMP_W_DEF = 3;
  localparam int TAKE_W_DEF  = 5;

  localparam int SRC_ALU  = 0;
  localparam int SRC_FPU  = 1;
  localparam int SRC_IMM  = 2;
  localparam int SRC_JUMP = 3;
  localparam int SRC_MOV  = 4;

  // Bit offset of the value field for (source, lane) in a flat source bus.
  function automatic int lane_lsb(input int src, input int lane, input int n_reg, input int w);
    return (src * n_reg + lane) * w;
  endfunction

  // Bit position of the potential flag for (source, lane).
  function automatic int pot_bit(input int src, input int lane, input int n_reg);
    return src * n_reg + lane;
  endfunction

endpackage

// File: rtl/pool_arb_grant.sv
// Combinational lane-conflict grant: walks sources from the start index downward
// (with wrap) and grants each source whose lanes are all still unclaimed.
module pool_arb_grant #(
  parameter int N_SRC = 5,
  parameter int N_REG = 8,
  parameter int PTR_W = 3
) (
  input  logic [N_SRC*N_REG-1:0] stamp_mask,
  input  logic [N_SRC*N_REG-1:0] take_mask,
  input  logic [PTR_W-1:0]       start,
  output logic [N_SRC-1:0]       grant
);

  logic [N_REG-1:0] claim_s;
  logic [N_REG-1:0] claim_t;
  logic [N_REG-1:0] sm;
  logic [N_REG-1:0] tm;
  int               s;

  always_comb begin
    grant   = '0;
    claim_s = '0;
    claim_t = '0;
    sm      = '0;
    tm      = '0;
    s       = 0;
    for (int k = 0; k < N_SRC; k++) begin
      s = int'(start) - k;
      if (s < 0) s = s + N_SRC;
      sm = stamp_mask[s*N_REG +: N_REG];
      tm = take_mask[s*N_REG +: N_REG];
      // A source is all-or-nothing: any overlap with earlier claims blocks it.
      if ((sm | tm) != '0 && (sm & claim_s) == '0 && (tm & claim_t) == '0) begin
        grant[s] = 1'b1;
        claim_s  = claim_s | sm;
        claim_t  = claim_t | tm;
      end
    end
  end

endmodule

// File: rtl/pool_arb.sv
// Pool arbiter: merges non-conflicting source lane requests into one registered
// conveyor word. Define POOL_ARB_RR_EN for rotating priority; default is fixed.
module pool_arb
  import pool_pkg::*;
#(
  parameter int N_SRC   = N_SRC_DEF,
  parameter int N_REG   = N_REG_DEF,
  parameter int STAMP_W = STAMP_W_DEF,
  parameter int TAKE_W  = TAKE_W_DEF
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [N_SRC*N_REG*STAMP_W-1:0]    src_stamp_flat,
  input  logic [N_SRC*N_REG-1:0]            src_stamp_in,
  input  logic [N_SRC*N_REG*TAKE_W-1:0]     src_take_flat,
  input  logic [N_SRC*N_REG-1:0]            src_take_in,
  output logic [N_SRC-1:0]                  src_ack,
  output logic [N_REG*STAMP_W-1:0]          conveyor_stamp_flat,
  output logic [N_REG-1:0]                  conveyor_stamp_in,
  output logic [N_REG*TAKE_W-1:0]           conveyor_take_flat,
  output logic [N_REG-1:0]                  conveyor_take_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [15:0]                       conflict_cnt
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]         req;
  logic [N_SRC-1:0]         grant;
  logic [PTR_W-1:0]         start;
  logic                     load;

  logic                     out_valid_q, out_valid_d;
  logic [N_REG-1:0]         stamp_in_q, stamp_in_d;
  logic [N_REG-1:0]         take_in_q, take_in_d;
  logic [N_REG*STAMP_W-1:0] stamp_flat_q, stamp_flat_d;
  logic [N_REG*TAKE_W-1:0]  take_flat_q, take_flat_d;
  logic [15:0]              cnt_q, cnt_d;

  always_comb begin
    req = '0;
    for (int s = 0; s < N_SRC; s++) begin
      req[s] = (|src_stamp_in[s*N_REG +: N_REG]) | (|src_take_in[s*N_REG +: N_REG]);
    end
  end

  assign load = !out_valid_q || out_ready;

  pool_arb_grant #(
    .N_SRC (N_SRC),
    .N_REG (N_REG),
    .PTR_W (PTR_W)
  ) u_grant (
    .stamp_mask (src_stamp_in),
    .take_mask  (src_take_in),
    .start      (start),
    .grant      (grant)
  );

`ifdef POOL_ARB_RR_EN
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  assign start = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (load && (|grant)) begin
      rr_ptr_d = (rr_ptr_q == '0) ? PTR_W'(N_SRC - 1) : rr_ptr_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= PTR_W'(N_SRC - 1);
    else          rr_ptr_q <= rr_ptr_d;
  end
`else
  assign start = PTR_W'(N_SRC - 1);
`endif

  always_comb begin
    out_valid_d  = out_valid_q;
    stamp_in_d   = stamp_in_q;
    take_in_d    = take_in_q;
    stamp_flat_d = stamp_flat_q;
    take_flat_d  = take_flat_q;
    cnt_d        = cnt_q;
    if (load) begin
      out_valid_d  = |grant;
      stamp_in_d   = '0;
      take_in_d    = '0;
      stamp_flat_d = '0;
      take_flat_d  = '0;
      // Value fields are only taken from lanes the granted source actually asserts.
      for (int s = 0; s < N_SRC; s++) begin
        for (int i = 0; i < N_REG; i++) begin
          if (grant[s] && src_stamp_in[pot_bit(s, i, N_REG)]) begin
            stamp_in_d[i] = 1'b1;
            stamp_flat_d[i*STAMP_W +: STAMP_W] = stamp_flat_d[i*STAMP_W +: STAMP_W]
              | src_stamp_flat[lane_lsb(s, i, N_REG, STAMP_W) +: STAMP_W];
          end
          if (grant[s] && src_take_in[pot_bit(s, i, N_REG)]) begin
            take_in_d[i] = 1'b1;
            take_flat_d[i*TAKE_W +: TAKE_W] = take_flat_d[i*TAKE_W +: TAKE_W]
              | src_take_flat[lane_lsb(s, i, N_REG, TAKE_W) +: TAKE_W];
          end
        end
      end
      if ((req & ~grant) != '0 && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      stamp_in_q   <= '0;
      take_in_q    <= '0;
      stamp_flat_q <= '0;
      take_flat_q  <= '0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      stamp_in_q   <= stamp_in_d;
      take_in_q    <= take_in_d;
      stamp_flat_q <= stamp_flat_d;
      take_flat_q  <= take_flat_d;
      cnt_q        <= cnt_d;
    end
  end

  assign src_ack             = reset_n ? (grant & {N_SRC{load}}) : '0;
  assign out_valid           = out_valid_q;
  assign conveyor_stamp_in   = stamp_in_q;
  assign conveyor_take_in    = take_in_q;
  assign conveyor_stamp_flat = stamp_flat_q;
  assign conveyor_take_flat  = take_flat_q;
  assign conflict_cnt        = cnt_q;

endmodule

// File: tb/tb_pool_arb.sv
// Scoreboard bench for pool_arb: a request-level source model predicts grants and
// conveyor words; a negedge monitor pops and compares each transferred word.
module tb_pool_arb;

  localparam int NS = 5;
  localparam int NR = 8;
  localparam int SW = 3;
  localparam int TW = 5;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [NS*NR*SW-1:0]    src_stamp_flat = '0;
  logic [NS*NR-1:0]       src_stamp_in = '0;
  logic [NS*NR*TW-1:0]    src_take_flat = '0;
  logic [NS*NR-1:0]       src_take_in = '0;
  logic [NS-1:0]          src_ack;
  logic [NR*SW-1:0]       conveyor_stamp_flat;
  logic [NR-1:0]          conveyor_stamp_in;
  logic [NR*TW-1:0]       conveyor_take_flat;
  logic [NR-1:0]          conveyor_take_in;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [15:0]            conflict_cnt;

  pool_arb #(.N_SRC(NS), .N_REG(NR), .STAMP_W(SW), .TAKE_W(TW)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .src_stamp_flat      (src_stamp_flat),
    .src_stamp_in        (src_stamp_in),
    .src_take_flat       (src_take_flat),
    .src_take_in         (src_take_in),
    .src_ack             (src_ack),
    .conveyor_stamp_flat (conveyor_stamp_flat),
    .conveyor_stamp_in   (conveyor_stamp_in),
    .conveyor_take_flat  (conveyor_take_flat),
    .conveyor_take_in    (conveyor_take_in),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .conflict_cnt        (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0]    sin;
    logic [NR-1:0]    tin;
    logic [NR*SW-1:0] sf;
    logic [NR*TW-1:0] tf;
  } word_t;

  word_t          exp_q[$];
  int             checks = 0;
  int             errors = 0;

  bit             pend[NS];
  logic [NR-1:0]  p_sm[NS];
  logic [NR-1:0]  p_tm[NS];
  logic [SW-1:0]  p_sv[NS][NR];
  logic [TW-1:0]  p_tv[NS][NR];
  bit             valid_m;
  int             conf_m;
  int             rr_m;
  logic [NS-1:0]  last_ack;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int s, input logic [NR-1:0] sm, input logic [NR-1:0] tm);
    pend[s] = 1'b1;
    p_sm[s] = sm;
    p_tm[s] = tm;
    for (int i = 0; i < NR; i++) begin
      p_sv[s][i] = SW'($urandom);
      p_tv[s][i] = TW'($urandom);
    end
  endtask

  task automatic rand_req(input int s);
    logic [NR-1:0] sm, tm;
    sm = NR'($urandom & $urandom & $urandom);
    tm = NR'($urandom & $urandom & $urandom);
    if ((sm | tm) == '0) sm[$urandom_range(0, NR-1)] = 1'b1;
    set_req(s, sm, tm);
  endtask

  task automatic drive();
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < NR; i++) begin
        src_stamp_flat[(s*NR+i)*SW +: SW] = p_sv[s][i];
        src_take_flat[(s*NR+i)*TW +: TW]  = p_tv[s][i];
        src_stamp_in[s*NR+i] = pend[s] & p_sm[s][i];
        src_take_in[s*NR+i]  = pend[s] & p_tm[s][i];
      end
    end
  endtask

  // Spec rule: visit sources from the priority head downward, grant if no lane overlap.
  function automatic logic [NS-1:0] model_grant();
    logic [NR-1:0] cs, ct;
    logic [NS-1:0] g;
    int head, s;
    cs = '0; ct = '0; g = '0;
`ifdef POOL_ARB_RR_EN
    head = rr_m;
`else
    head = NS - 1;
`endif
    for (int k = 0; k < NS; k++) begin
      s = (head - k + NS) % NS;
      if (pend[s] && (p_sm[s] & cs) == '0 && (p_tm[s] & ct) == '0) begin
        g[s] = 1'b1;
        cs = cs | p_sm[s];
        ct = ct | p_tm[s];
      end
    end
    return g;
  endfunction

  // Entered shortly after a rising edge; leaves 1 time unit after the next one.
  task automatic tick();
    logic [NS-1:0] g, reqv, exp_ack;
    word_t w;
    bit ld;
    drive();
    #2;
    g = model_grant();
    reqv = '0;
    for (int s = 0; s < NS; s++) reqv[s] = pend[s];
    ld = !valid_m || out_ready;
    exp_ack = ld ? g : '0;
    last_ack = src_ack;
    chk("src_ack", 64'(src_ack), 64'(exp_ack));
    if (ld) begin
      if (g != '0) begin
        w.sin = '0; w.tin = '0; w.sf = '0; w.tf = '0;
        for (int s = 0; s < NS; s++) begin
          if (g[s]) begin
            for (int i = 0; i < NR; i++) begin
              if (p_sm[s][i]) begin w.sin[i] = 1'b1; w.sf[i*SW +: SW] = p_sv[s][i]; end
              if (p_tm[s][i]) begin w.tin[i] = 1'b1; w.tf[i*TW +: TW] = p_tv[s][i]; end
            end
            pend[s] = 1'b0;
          end
        end
        exp_q.push_back(w);
      end
      valid_m = (g != '0);
      if ((reqv & ~g) != '0 && conf_m < 65535) conf_m++;
`ifdef POOL_ARB_RR_EN
      if (g != '0) rr_m = (rr_m == 0) ? NS - 1 : rr_m - 1;
`endif
    end
    @(posedge clk);
    #1;
    chk("conflict_cnt", 64'(conflict_cnt), 64'(conf_m));
    chk("out_valid", 64'(out_valid), 64'(valid_m));
  endtask

  task automatic do_reset(input bit keep);
    reset_n = 1'b0;
    exp_q.delete();
    valid_m = 1'b0;
    conf_m  = 0;
    rr_m    = NS - 1;
    if (!keep) for (int s = 0; s < NS; s++) pend[s] = 1'b0;
    drive();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_conflict", 64'(conflict_cnt), 64'(0));
    chk("rst_src_ack", 64'(src_ack), 64'(0));
    chk("rst_conv_stamp_in", 64'(conveyor_stamp_in), 64'(0));
    chk("rst_conv_take_flat", 64'(conveyor_take_flat), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_unexpected actual=stamp_in %0h required=no word", conveyor_stamp_in);
        end else begin
          w = exp_q.pop_front();
          chk("word_stamp_in", 64'(conveyor_stamp_in), 64'(w.sin));
          chk("word_take_in", 64'(conveyor_take_in), 64'(w.tin));
          chk("word_stamp_flat", 64'(conveyor_stamp_flat), 64'(w.sf));
          chk("word_take_flat", 64'(conveyor_take_flat), 64'(w.tf));
        end
      end
    end
  end

  initial begin
    logic [NR-1:0]    h_sin;
    logic [NR*SW-1:0] h_sf;
    logic [15:0]      h_cnt;
    int               n;

    for (int s = 0; s < NS; s++) begin
      pend[s] = 1'b0; p_sm[s] = '0; p_tm[s] = '0;
      for (int i = 0; i < NR; i++) begin p_sv[s][i] = '0; p_tv[s][i] = '0; end
    end
    do_reset(1'b0);

    // single ALU stamp lane
    out_ready = 1'b1;
    set_req(0, 8'h01, 8'h00);
    p_sv[0][0] = 3'd5;
    tick();
    chk("s1_ack", 64'(last_ack), 64'(5'b00001));
    chk("s1_stamp_in", 64'(conveyor_stamp_in), 64'(8'h01));
    chk("s1_stamp_lane0", 64'(conveyor_stamp_flat[2:0]), 64'(3'd5));

    // ALU vs MOV on take lane 3
    do_reset(1'b0);
    out_ready = 1'b1;
    set_req(0, 8'h00, 8'h08);
    set_req(4, 8'h00, 8'h08);
    tick();
    chk("s2_first_ack", 64'(last_ack), 64'(5'b10000));
    tick();
    chk("s2_second_ack", 64'(last_ack), 64'(5'b00001));
    chk("s2_conflict", 64'(conflict_cnt), 64'(1));

    // FPU and IMM disjoint, merged in one word
    do_reset(1'b0);
    out_ready = 1'b1;
    set_req(1, 8'h06, 8'h00);
    set_req(2, 8'h10, 8'h00);
    tick();
    chk("s3_ack", 64'(last_ack), 64'(5'b00110));
    chk("s3_stamp_in", 64'(conveyor_stamp_in), 64'(8'h16));

    // stall for three cycles with a waiting requester
    out_ready = 1'b0;
    set_req(0, 8'h01, 8'h00);
    h_sin = conveyor_stamp_in;
    h_sf  = conveyor_stamp_flat;
    h_cnt = conflict_cnt;
    repeat (3) begin
      tick();
      chk("s4_ack_zero", 64'(last_ack), 64'(0));
      chk("s4_stamp_in_hold", 64'(conveyor_stamp_in), 64'(h_sin));
      chk("s4_stamp_flat_hold", 64'(conveyor_stamp_flat), 64'(h_sf));
      chk("s4_conflict_hold", 64'(conflict_cnt), 64'(h_cnt));
    end

    // reset mid-stall: held word dropped, ALU re-presents its request
    do_reset(1'b1);
    out_ready = 1'b1;
    tick();
    chk("s4_repost_ack", 64'(last_ack), 64'(5'b00001));

    // all five on stamp lane 0
    do_reset(1'b0);
    out_ready = 1'b1;
    for (int s = 0; s < NS; s++) set_req(s, 8'h01, 8'h00);
    for (int k = 0; k < NS; k++) begin
      tick();
      chk("s5_order", 64'(last_ack), 64'(5'b10000 >> k));
    end
    chk("s5_conflict", 64'(conflict_cnt), 64'(4));

    // randomized traffic with random back-pressure
    do_reset(1'b0);
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < NS; s++) if (!pend[s] && $urandom_range(0, 2) == 0) rand_req(s);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    n = 0;
    while (n < 60 && (exp_q.size() != 0 || pend[0] || pend[1] || pend[2] || pend[3] || pend[4])) begin
      tick();
      n++;
    end
    #3;
    chk("drain_queue", 64'(exp_q.size()), 64'(0));

    // saturate the conflict counter, then reset asynchronously
    do_reset(1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 65540; c++) begin
      if (!pend[0]) set_req(0, 8'h01, 8'h00);
      if (!pend[1]) set_req(1, 8'h01, 8'h00);
      tick();
    end
    chk("s6_saturated", 64'(conflict_cnt), 64'(16'hFFFF));
    reset_n = 1'b0;
    #1;
    chk("s6_rst_conflict", 64'(conflict_cnt), 64'(0));
    chk("s6_rst_valid", 64'(out_valid), 64'(0));
    chk("s6_rst_ack", 64'(src_ack), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_arb.md
POOL_ARB -- requirements
Module: pool_arb

Interface
REQ-001 SHALL have parameter N_SRC, default 5: number of execution-unit sources; index 0 = ALU, 1 = FPU, 2 = IMM, 3 = JUMP, 4 = MOV.
REQ-002 SHALL have parameter N_REG, default 8: register lanes a..h.
REQ-003 SHALL have parameter STAMP_W, default 3: stamp field width per lane.
REQ-004 SHALL have parameter TAKE_W, default 5: take field width per lane.
REQ-005 SHALL have ports: clk input 1, the single clock; reset_n input 1, asynchronous active-low reset.
REQ-006 SHALL have port src_stamp_flat input N_SRC*N_REG*STAMP_W: source s, lane i at bits [(s*N_REG+i)*STAMP_W +: STAMP_W].
REQ-007 SHALL have port src_stamp_in input N_SRC*N_REG: stamp potentials, bit s*N_REG+i.
REQ-008 SHALL have port src_take_flat input N_SRC*N_REG*TAKE_W, packed the same way as src_stamp_flat.
REQ-009 SHALL have port src_take_in input N_SRC*N_REG: take potentials, packed the same way as src_stamp_in.
REQ-010 SHALL have port src_ack output N_SRC: source s request consumed this cycle.
REQ-011 SHALL have ports: conveyor_stamp_flat output N_REG*STAMP_W; conveyor_stamp_in output N_REG; conveyor_take_flat output N_REG*TAKE_W; conveyor_take_in output N_REG.
REQ-012 SHALL have ports: out_valid output 1; out_ready input 1, conveyor accepts.
REQ-013 SHALL have port conflict_cnt output 16: saturating count of arbitration conflicts.

Function
REQ-014 Source s SHALL be requesting when any of its stamp_in or take_in bits is 1.
REQ-015 Stage load enable SHALL be load = !out_valid || out_ready.
REQ-016 Arbitration SHALL visit sources highest-priority first, granting a requesting source only if none of its asserted stamp lanes and none of its asserted take lanes is already claimed by an earlier-granted source. Grants are atomic per source; a partial grant is never made.
REQ-017 src_ack SHALL be the combinational grant vector ANDed with load; when load=0, src_ack SHALL be all zero.
REQ-018 Un-acked requesting sources SHALL hold their inputs; pool_arb SHALL NOT drop or split any request.
REQ-019 On load, the output register SHALL capture the OR-merge of all granted sources' lanes. Lanes not claimed SHALL have value 0 and potential 0.
REQ-020 Latency SHALL be 1 cycle from grant to conveyor outputs.
REQ-021 out_valid SHALL be set on load when at least one source is granted; otherwise it is cleared on load.
REQ-022 When out_valid=1 and out_ready=0, all outputs SHALL hold stable and src_ack SHALL be 0.
REQ-023 conflict_cnt SHALL increment by 1 on each load cycle in which at least one requesting source is not granted, and SHALL saturate at 16'hFFFF.
REQ-024 A source requesting with zero asserted lanes SHALL be impossible by REQ-014 and needs no handling.

Reset
REQ-025 While reset_n=0, asynchronously: out_valid=0, all conveyor_* outputs 0, conflict_cnt=0, rotation pointer=N_SRC-1.
REQ-026 Reset asserted mid-stall SHALL discard the held output word; sources whose request was not acked SHALL re-present it after reset.
REQ-027 src_ack SHALL be 0 while reset_n=0.

Configuration
REQ-028 Macro POOL_ARB_RR_EN defined: priority SHALL rotate. The order is rr_ptr, rr_ptr-1, ... with wrap modulo N_SRC. rr_ptr SHALL decrement with wrap after every load that grants at least one source.
REQ-029 POOL_ARB_RR_EN undefined: fixed priority SHALL apply, highest index first (MOV > JUMP > IMM > FPU > ALU). No pointer register SHALL exist.

Structure
REQ-030 Package pool_pkg SHALL hold: default parameter constants; source index constants SRC_ALU..SRC_MOV; lane field extraction functions.
REQ-031 Combinational grant logic SHALL live in sub-module pool_arb_grant (inputs: lane-request masks and the priority start index; output: grant vector). The registers and counter stay in pool_arb.

Verification
REQ-032 Scenario 1: after reset, ALU stamp lane 0 = 3'd5 with out_ready=1 -> src_ack=5'b00001; next cycle conveyor_stamp_in=8'h01, stamp lane 0 = 5, out_valid=1.
REQ-033 Scenario 2: ALU and MOV both assert take lane 3, fixed priority -> MOV acked; ALU acked the following cycle; conflict_cnt=1.
REQ-034 Scenario 3: FPU lanes 1,2 and IMM lane 4 with no overlap -> both acked the same cycle; output carries both sources' lanes merged.
REQ-035 Scenario 4: out_ready=0 for 3 cycles while out_valid=1 -> outputs stable, src_ack=0 throughout, conflict_cnt unchanged.
REQ-036 Scenario 5: with POOL_ARB_RR_EN, all 5 sources contend on lane 0 for 5 loads -> grant order MOV, JUMP, IMM, FPU, ALU; conflict_cnt=4.
REQ-037 Scenario 6: force conflicts for 65540 cycles -> conflict_cnt=16'hFFFF; then reset_n pulse -> conflict_cnt=0 and out_valid=0 immediately.
